// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD adder: FSM state encodings,
// BCD digit constants and the invalid-digit scan helper.
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ = 4'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Flags any of the lowest n packed digits that lies outside 0..9.
  function automatic logic bcd_any_invalid(input logic [31:0] v, input int n);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ((i < n) && (v[4*i +: 4] > BCD_MAX)) begin
        bad = 1'b1;
      end
    end
    return bad;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational one-digit BCD adder; raw sums above 9 are corrected by +6
// with the result taken mod 16, so out-of-range inputs still give a fixed answer.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] raw_s;

  // Raw binary sum followed by the decimal correction.
  always_comb begin
    raw_s = {1'b0, x} + {1'b0, y} + {4'b0000, ci};
    if (raw_s > {1'b0, BCD_MAX}) begin
      s  = raw_s[3:0] + BCD_ADJ;
      co = 1'b1;
    end else begin
      s  = raw_s[3:0];
      co = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial BCD add sequencer around one shared bcd_digit_add.
// Optional feature macro: BCD_SUBTRACT_EN (adds Sub port, ten's-complement subtract).
module bcd_serial_adder_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  Start,
  input  logic [4*DIGITS-1:0]   X,
  input  logic [4*DIGITS-1:0]   Y,
  input  logic                  Cin,
`ifdef BCD_SUBTRACT_EN
  input  logic                  Sub,
`endif
  output logic [4*DIGITS-1:0]   Sum,
  output logic                  Cout,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Err
);

  localparam int W  = DIGIT_W * DIGITS;
  localparam int CW = $clog2(DIGITS);

  state_e        state_r;
  logic [W-1:0]  x_r;
  logic [W-1:0]  y_r;
  logic [W-1:0]  acc_r;
  logic          c_r;
  logic          err_pend_r;
  logic [CW-1:0] cnt_r;

  logic [W-1:0]  y_cap_s;
  logic          c_cap_s;
  logic          err_cap_s;
  logic [3:0]    dig_s;
  logic          co_s;
  logic          last_s;
  logic [W-1:0]  acc_next_s;

  // Operand conditioning at capture; Err always looks at the Y as presented.
  always_comb begin
    y_cap_s   = Y;
    c_cap_s   = Cin;
    err_cap_s = bcd_any_invalid(32'(X), DIGITS) | bcd_any_invalid(32'(Y), DIGITS);
`ifdef BCD_SUBTRACT_EN
    if (Sub) begin
      for (int i = 0; i < DIGITS; i++) begin
        y_cap_s[4*i +: 4] = BCD_MAX - Y[4*i +: 4];
      end
      c_cap_s = 1'b1;
    end else begin
      y_cap_s = Y;
      c_cap_s = Cin;
    end
`endif
  end

  bcd_digit_add u_digit (
    .x  (x_r[3:0]),
    .y  (y_r[3:0]),
    .ci (c_r),
    .s  (dig_s),
    .co (co_s)
  );

  assign last_s     = (cnt_r == CW'(DIGITS - 1));
  assign acc_next_s = {dig_s, acc_r[W-1:4]};

  // Sequencer FSM; results are published on the final ADD edge so they are
  // visible exactly in the DONE cycle and never expose partial sums.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r    <= IDLE;
      x_r        <= '0;
      y_r        <= '0;
      acc_r      <= '0;
      c_r        <= 1'b0;
      err_pend_r <= 1'b0;
      cnt_r      <= '0;
      Sum        <= '0;
      Cout       <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Err        <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          Done <= 1'b0;
          if (Start) begin
            x_r        <= X;
            y_r        <= y_cap_s;
            c_r        <= c_cap_s;
            acc_r      <= '0;
            err_pend_r <= err_cap_s;
            cnt_r      <= '0;
            Busy       <= 1'b1;
            state_r    <= ADD;
          end else begin
            Busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        ADD: begin
          x_r   <= {4'd0, x_r[W-1:4]};
          y_r   <= {4'd0, y_r[W-1:4]};
          c_r   <= co_s;
          acc_r <= acc_next_s;
          cnt_r <= cnt_r + CW'(1);
          if (last_s) begin
            Sum     <= acc_next_s;
            Cout    <= co_s;
            Err     <= err_pend_r;
            Busy    <= 1'b0;
            Done    <= 1'b1;
            state_r <= DONE;
          end else begin
            Busy    <= 1'b1;
            Done    <= 1'b0;
            state_r <= ADD;
          end
        end
        default: begin
          Busy    <= 1'b0;
          Done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/bcd_serial_adder_ctrl.md
# bcd_serial_adder_ctrl

Digit-serial sequencer for multi-digit BCD addition, built around a single one-digit BCD adder. It captures two packed DIGITS-wide BCD operands on a start request and steps the shared digit adder from least-significant to most-significant digit, one digit per clock. It then publishes the registered sum, the carry-out and an invalid-digit flag. It sits between switch/register operands and the 7-segment display decoders in board-level top modules.

## Interface
Parameters:
- DIGITS, 4, number of BCD digits per operand; legal range 2..8.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Start  in  1  request to begin an operation; level-sampled.
- X  in  4*DIGITS  operand X, packed BCD; digit i is X[4i+3:4i].
- Y  in  4*DIGITS  operand Y, packed BCD.
- Cin  in  1  carry into digit 0.
- Sub  in  1  subtract request. Present only with BCD_SUBTRACT_EN.
- Sum  out  4*DIGITS  registered BCD result.
- Cout  out  1  carry out of the most-significant digit.
- Busy  out  1  high while digits are being processed.
- Done  out  1  one-cycle completion pulse.
- Err  out  1  high if any captured X or Y digit is greater than 9.

## Operation
- States: IDLE, ADD, DONE.
- IDLE or DONE with Start=1:
  - Capture X, Y and Cin into working shift registers.
  - Clear the digit counter to 0.
  - Compute Err for this operation.
  - Go to ADD.
- ADD, one cycle per digit:
  - The digit adder takes the low working digits plus the carry register.
  - Raw sum r = x + y + c, 5 bits.
  - If r > 9: digit = (r + 6) mod 16, carry = 1. Otherwise digit = r, carry = 0.
  - The result digit shifts into the working sum from the top; both operand registers shift right by 4.
  - When the counter reaches DIGITS-1, go to DONE.
- DONE, one cycle:
  - Load Sum from the working sum and Cout from the carry register.
  - Assert Done.
  - Go to IDLE, or to ADD if Start=1.
- Sum, Cout and Err hold their values until the next DONE. Display logic never sees partial results.
- Invalid digits (greater than 9) are not rejected. They run through the same correction rule, so the result is deterministic, and Err=1 for that operation.
- Start in ADD is ignored. No queueing.

## Timing
- Reset (asynchronous, Resetn=0):
  - State goes to IDLE.
  - Sum=0, Cout=0, Busy=0, Done=0, Err=0.
  - Working registers are cleared.
  - Reset in the middle of ADD aborts the operation; no partial result is published.
- Start is sampled at edge k.
- Busy=1 for cycles k+1 .. k+DIGITS.
- Done=1 and the new Sum/Cout/Err are visible in cycle k+DIGITS+1.
- Latency is DIGITS+1 clocks from the Start edge to Done.
- Back-to-back operation: Start held high during DONE begins the next operation at that edge. Throughput is one result per DIGITS+1 clocks.
- Busy and Done are never high in the same cycle.
- Err is registered together with Sum, not at capture.

## Configuration
- Macro: BCD_SUBTRACT_EN.
- Defined:
  - The Sub port exists.
  - When Sub=1 at Start, each Y digit is replaced at capture by its nine's complement (9 - y), and the carry into digit 0 is forced to 1. This computes X - Y in ten's complement.
  - Cout=1 means X >= Y.
  - Cout=0 means a negative result; Sum then holds the ten's complement.
  - Err is evaluated on the original, uncomplemented Y.
- Undefined: no Sub port; addition only; Cin is used as given.

## Structure
- Shared package/include bcd_pkg holds:
  - state encodings IDLE/ADD/DONE;
  - BCD_MAX = 9 and BCD_ADJ = 6;
  - the 4-bit digit width constant.
- One sub-module, bcd_digit_add: combinational one-digit BCD adder.
  - Inputs: x[3:0], y[3:0], ci.
  - Outputs: s[3:0], co.
  - Uses the correction rule above.
- The sequencer owns all registers, the digit counter and the FSM.

## Test plan
All scenarios use DIGITS=4.
- Basic add: X=1234, Y=5678, Cin=0, Start pulse -> Busy high for 4 cycles; Done in cycle 5; Sum=6912, Cout=0, Err=0.
- Carry ripple: X=9999, Y=0001 -> Sum=0000, Cout=1.
- Maximum with carry-in: X=9999, Y=9999, Cin=1 -> Sum=9999, Cout=1.
- Invalid digit: X=0x00A0, Y=0000 -> Sum=0x0100, Cout=0, Err=1. A following valid operation clears Err.
- Control:
  - Start pulses during Busy are ignored; exactly one Done.
  - Resetn low in the 2nd ADD cycle -> all outputs 0.
  - After reset, a new Start completes normally.
  - Start held high through DONE -> a second Done 5 cycles later.
- BCD_SUBTRACT_EN:
  - X=0500, Y=0123, Sub=1 -> Sum=0377, Cout=1.
  - X=0123, Y=0500, Sub=1 -> Sum=9623, Cout=0.
